// File: rtl/game_display_box_animator.sv
// ----------------------------------------------------------------------------
// game_display_box_animator
//
// Holds the live game-display rectangle that feeds the border renderer and
// slides each edge toward a requested target by at most STEP pixels per video
// frame. The rectangle only changes on a frame_tick edge, so the renderer
// never sees it move mid-frame.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   frame_tick             one-cycle pulse per frame (in blanking)
//   load                   one-cycle pulse: latch target_* (clamped)
//   target_x0/y0/x1/y1     requested rectangle edges
//   game_display_x0..y1    current rectangle edges (registered)
//   busy                   high while animating
//   done                   one-cycle pulse when the rectangle arrives
// ----------------------------------------------------------------------------
module game_display_box_animator #(
    parameter int BORDER  = 5,
    parameter int STEP    = 4,
    parameter int H_MAX   = 639,
    parameter int V_MAX   = 479,
    parameter int INIT_X0 = 220,
    parameter int INIT_Y0 = 250,
    parameter int INIT_X1 = 420,
    parameter int INIT_Y1 = 400
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       load,
    input  logic [9:0] target_x0,
    input  logic [9:0] target_y0,
    input  logic [9:0] target_x1,
    input  logic [9:0] target_y1,
    output logic [9:0] game_display_x0,
    output logic [9:0] game_display_y0,
    output logic [9:0] game_display_x1,
    output logic [9:0] game_display_y1,
    output logic       busy,
    output logic       done
);

    typedef enum logic {IDLE, MOVING} state_t;

    // Edge order inside the packed arrays: [0]=x0 [1]=y0 [2]=x1 [3]=y1
    localparam logic [3:0][9:0] INIT_RECT = {10'(INIT_Y1), 10'(INIT_X1),
                                             10'(INIT_Y0), 10'(INIT_X0)};

    localparam logic [10:0] LO    = 11'(BORDER);
    localparam logic [10:0] X_HI  = 11'(H_MAX - BORDER);
    localparam logic [10:0] Y_HI  = 11'(V_MAX - BORDER);
    localparam logic [9:0]  STEP_W = 10'(STEP);

    state_t          state_q, state_d;
    logic [3:0][9:0] cur_q, cur_d;
    logic [3:0][9:0] tgt_q, tgt_d;
    logic            done_q, done_d;
    logic [3:0][9:0] tgt_clamped;

    // Compares are done one bit wider so large requests clamp cleanly.
    function automatic logic [9:0] clamp(input logic [9:0] v,
                                         input logic [10:0] lo,
                                         input logic [10:0] hi);
        logic [10:0] v11;
        logic [10:0] r;
        v11 = {1'b0, v};
        if (v11 < lo)      r = lo;
        else if (v11 > hi) r = hi;
        else               r = v11;
        return r[9:0];
    endfunction

    // Move one edge toward its target by at most STEP.
    function automatic logic [9:0] step_edge(input logic [9:0] cur,
                                             input logic [9:0] tgt);
        logic [9:0] r;
        r = cur;
        if (cur < tgt)
            r = ((tgt - cur) > STEP_W) ? cur + STEP_W : tgt;
        else if (cur > tgt)
            r = ((cur - tgt) > STEP_W) ? cur - STEP_W : tgt;
        return r;
    endfunction

    // Clamp each edge to the on-screen range, then keep the far edges from
    // falling below the near ones so the target is never inverted.
    always_comb begin
        tgt_clamped[0] = clamp(target_x0, LO, X_HI);
        tgt_clamped[1] = clamp(target_y0, LO, Y_HI);
        tgt_clamped[2] = clamp(target_x1, LO, X_HI);
        tgt_clamped[3] = clamp(target_y1, LO, Y_HI);
        if (tgt_clamped[2] < tgt_clamped[0]) tgt_clamped[2] = tgt_clamped[0];
        if (tgt_clamped[3] < tgt_clamped[1]) tgt_clamped[3] = tgt_clamped[1];
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        tgt_d   = tgt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (load) begin
                    tgt_d   = tgt_clamped;
                    state_d = MOVING;
                end
            end
            MOVING: begin
                // A tick always steps toward the targets held this cycle.
                if (frame_tick) begin
                    for (int i = 0; i < 4; i++)
                        cur_d[i] = step_edge(cur_q[i], tgt_q[i]);
                    if (cur_d == tgt_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                // A new request overrides completion of the abandoned one.
                if (load) begin
                    tgt_d   = tgt_clamped;
                    state_d = MOVING;
                    done_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cur_q   <= INIT_RECT;
            tgt_q   <= INIT_RECT;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            tgt_q   <= tgt_d;
            done_q  <= done_d;
        end
    end

    assign game_display_x0 = cur_q[0];
    assign game_display_y0 = cur_q[1];
    assign game_display_x1 = cur_q[2];
    assign game_display_y1 = cur_q[3];
    assign busy            = (state_q == MOVING);
    assign done            = done_q;

endmodule

// File: tb/tb_game_display_box_animator.sv
// ----------------------------------------------------------------------------
// Bench for game_display_box_animator: directed scenarios followed by random
// ticks/loads, all checked every cycle against a behavioural rectangle model.
// ----------------------------------------------------------------------------
module tb_game_display_box_animator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       load = 1'b0;
    logic [9:0] target_x0 = '0, target_y0 = '0, target_x1 = '0, target_y1 = '0;
    logic [9:0] gd_x0, gd_y0, gd_x1, gd_y1;
    logic       busy, done;

    game_display_box_animator dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .frame_tick      (frame_tick),
        .load            (load),
        .target_x0       (target_x0),
        .target_y0       (target_y0),
        .target_x1       (target_x1),
        .target_y1       (target_y1),
        .game_display_x0 (gd_x0),
        .game_display_y0 (gd_y0),
        .game_display_x1 (gd_x1),
        .game_display_y1 (gd_y1),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Model state: current rectangle, latched target, animating flag, done.
    int m_cur[4];
    int m_tgt[4];
    bit m_moving;
    bit m_done;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction
    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic model_reset();
        m_cur = '{220, 250, 420, 400};
        m_tgt = '{220, 250, 420, 400};
        m_moving = 0;
        m_done = 0;
    endtask

    task automatic check_all(input string where);
        chk({where, ".x0"},   int'(gd_x0), m_cur[0]);
        chk({where, ".y0"},   int'(gd_y0), m_cur[1]);
        chk({where, ".x1"},   int'(gd_x1), m_cur[2]);
        chk({where, ".y1"},   int'(gd_y1), m_cur[3]);
        chk({where, ".busy"}, int'(busy),  int'(m_moving));
        chk({where, ".done"}, int'(done),  int'(m_done));
    endtask

    // Model of one clock edge given this cycle's inputs.
    task automatic model_edge(input bit tk, input bit ld, input int t[4]);
        bit arrived;
        bit nd;
        nd = 0;
        if (tk && m_moving) begin
            arrived = 1;
            for (int i = 0; i < 4; i++) begin
                int diff;
                diff = m_tgt[i] - m_cur[i];
                if (diff > 0)      m_cur[i] += imin(4, diff);
                else if (diff < 0) m_cur[i] -= imin(4, -diff);
                if (m_cur[i] != m_tgt[i]) arrived = 0;
            end
            if (arrived && !ld) begin
                m_moving = 0;
                nd = 1;
            end
        end
        if (ld) begin
            m_tgt[0] = imin(imax(t[0], 5), 634);
            m_tgt[1] = imin(imax(t[1], 5), 474);
            m_tgt[2] = imin(imax(t[2], 5), 634);
            m_tgt[3] = imin(imax(t[3], 5), 474);
            if (m_tgt[2] < m_tgt[0]) m_tgt[2] = m_tgt[0];
            if (m_tgt[3] < m_tgt[1]) m_tgt[3] = m_tgt[1];
            m_moving = 1;
        end
        m_done = nd;
    endtask

    // One cycle: check at negedge, drive inputs, advance model at posedge.
    task automatic cyc(input string where, input bit tk, input bit ld,
                       input int a, input int b, input int c, input int d);
        int t[4];
        t = '{a, b, c, d};
        check_all(where);
        frame_tick = tk;
        load = ld;
        target_x0 = 10'(a); target_y0 = 10'(b);
        target_x1 = 10'(c); target_y1 = 10'(d);
        @(posedge clk);
        model_edge(tk, ld, t);
        @(negedge clk);
        frame_tick = 1'b0;
        load = 1'b0;
    endtask

    task automatic idle_cyc(input string where, input bit tk);
        cyc(where, tk, 1'b0, 0, 0, 0, 0);
    endtask

    // Tick every third cycle until the model goes idle (bounded).
    task automatic run_to_idle(input string where);
        for (int k = 0; k < 400 && m_moving; k++) begin
            idle_cyc(where, 1'b1);
            idle_cyc(where, 1'b0);
            idle_cyc(where, 1'b0);
        end
        chk({where, ".settled"}, int'(m_moving), 0);
        idle_cyc(where, 1'b0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;

        // 1: ticks in idle do nothing
        for (int i = 0; i < 3; i++) begin
            idle_cyc("idle_tick", 1'b1);
            idle_cyc("idle_tick", 1'b0);
        end

        // 2: widen x by 20 on each side
        cyc("widen_load", 1'b0, 1'b1, 200, 250, 440, 400);
        run_to_idle("widen");

        // 3: out-of-range request clamps to the screen minus border
        cyc("clamp_load", 1'b0, 1'b1, 0, 0, 1023, 1023);
        chk("clamp.tgt_x1", m_tgt[2], 634);
        run_to_idle("clamp");
        chk("clamp.end_x1", int'(gd_x1), 634);
        chk("clamp.end_y1", int'(gd_y1), 474);

        // 4: inverted x request collapses to zero width
        cyc("inv_load", 1'b0, 1'b1, 300, 100, 250, 200);
        run_to_idle("inv");
        chk("inv.width", int'(gd_x1) - int'(gd_x0), 0);

        // Back to the reset box, then 5: retarget with a coincident tick
        cyc("home_load", 1'b0, 1'b1, 220, 250, 420, 400);
        run_to_idle("home");
        cyc("rt_load", 1'b0, 1'b1, 200, 250, 440, 400);
        idle_cyc("rt", 1'b1);
        idle_cyc("rt", 1'b1);
        cyc("rt_swap", 1'b1, 1'b1, 220, 250, 420, 400);
        run_to_idle("rt_back");

        // Load equal to current: one tick then done
        cyc("same_load", 1'b0, 1'b1, 220, 250, 420, 400);
        idle_cyc("same", 1'b1);
        idle_cyc("same", 1'b0);

        // Load while moving on the tick that would finish the old target
        cyc("fin_load", 1'b0, 1'b1, 224, 250, 420, 400);
        cyc("fin_swap", 1'b1, 1'b1, 240, 250, 420, 400);
        run_to_idle("fin");

        // 6: asynchronous reset mid-animation
        cyc("rst_load", 1'b0, 1'b1, 100, 100, 600, 450);
        idle_cyc("rst_mv", 1'b1);
        idle_cyc("rst_mv", 1'b1);
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) idle_cyc("post_rst", 1'b1);

        // Random ticks and loads
        for (int i = 0; i < 3000; i++) begin
            bit tk, ld;
            tk = ($urandom_range(0, 3) == 0);
            ld = ($urandom_range(0, 39) == 0);
            cyc("rand", tk, ld, int'($urandom_range(0, 1023)),
                int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                int'($urandom_range(0, 1023)));
        end
        run_to_idle("rand_end");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
